// File: rtl/xm_pkg.sv
// Shared types and constants for the instruction fetch slice.
package xm_pkg;
  localparam int              WORD      = 16;
  localparam logic [WORD-1:0] RESET_VEC = 16'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;
endpackage

// File: rtl/fetch_timeout_cnt.sv
// Wait-state counter for the memory handshake; expire_o flags the final allowed REQ cycle.
module fetch_timeout_cnt #(
  parameter int TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic arst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  logic [7:0] r_cnt;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)  r_cnt <= '0;
    else if (clr_i) r_cnt <= '0;
    else if (en_i)  r_cnt <= r_cnt + 8'd1;
  end

  // Expires on the cycle whose increment would make the count reach TIMEOUT.
  assign expire_o = en_i && (r_cnt == 8'(TIMEOUT - 1));
endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch unit: owns the PC, runs the instruction-memory handshake, latches the fetched word.
module instruction_fetch_unit
  import xm_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic            clk_i,
  input  logic            arst_n_i,
  input  logic            fetch_i,
  input  logic            pc_upd_i,
  input  logic [WORD-1:0] pc_next_i,
  input  logic            pc_wr_i,
  input  logic [WORD-1:0] pc_data_i,
  input  logic            mem_rdy_i,
  input  logic [WORD-1:0] mem_data_i,
  output logic [WORD-1:0] pc_o,
  output logic            mem_req_o,
  output logic [WORD-1:0] mem_addr_o,
  output logic [WORD-1:0] ir_o,
  output logic            done_o,
  output logic            busy_o,
  output logic            fault_o
);
  fetch_state_t    r_state, w_state_nxt;
  logic [WORD-1:0] r_pc, r_ir, r_addr;
  logic            r_req, r_done, r_fault;
  logic            w_cnt_clr, w_cnt_en, w_expire, w_ld_ir;

  fetch_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .clr_i    (w_cnt_clr),
    .en_i     (w_cnt_en),
    .expire_o (w_expire)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_cnt_en    = 1'b0;
    w_ld_ir     = 1'b0;
    case (r_state)
      IDLE: begin
        if (fetch_i) begin
          if (r_pc[0]) begin
            w_state_nxt = FAULT;
          end else begin
            w_state_nxt = REQ;
            w_cnt_clr   = 1'b1;
          end
        end
      end
      REQ: begin
        if (mem_rdy_i) begin
          w_ld_ir     = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_cnt_en = 1'b1;
          if (w_expire) w_state_nxt = FAULT;
        end
      end
      DONE:    w_state_nxt = IDLE;
      FAULT:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state <= IDLE;
      r_pc    <= RESET_VEC;
      r_ir    <= '0;
      r_addr  <= '0;
      r_req   <= 1'b0;
      r_done  <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= (w_state_nxt == REQ);
      r_done  <= (w_state_nxt == DONE);
      r_fault <= (w_state_nxt == FAULT);
      if (w_ld_ir)   r_ir   <= mem_data_i;
      if (w_cnt_clr) r_addr <= r_pc;
      // PC only moves in IDLE; a fetch launched this cycle already captured the old PC.
      if (r_state == IDLE) begin
        if (pc_wr_i)       r_pc <= pc_data_i;
        else if (pc_upd_i) r_pc <= pc_next_i;
      end
    end
  end

  assign pc_o       = r_pc;
  assign ir_o       = r_ir;
  assign mem_addr_o = r_addr;
  assign mem_req_o  = r_req;
  assign done_o     = r_done;
  assign fault_o    = r_fault;
  assign busy_o     = (r_state != IDLE);
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit against a transaction-level fetch model.
module tb_instruction_fetch_unit;
  localparam int TMO = 15;

  logic        clk_i = 1'b0;
  logic        arst_n_i;
  logic        fetch_i, pc_upd_i, pc_wr_i, mem_rdy_i;
  logic [15:0] pc_next_i, pc_data_i, mem_data_i;
  logic [15:0] pc_o, mem_addr_o, ir_o;
  logic        mem_req_o, done_o, busy_o, fault_o;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] m_pc, m_ir;

  instruction_fetch_unit #(.TIMEOUT(TMO)) dut (
    .clk_i      (clk_i),
    .arst_n_i   (arst_n_i),
    .fetch_i    (fetch_i),
    .pc_upd_i   (pc_upd_i),
    .pc_next_i  (pc_next_i),
    .pc_wr_i    (pc_wr_i),
    .pc_data_i  (pc_data_i),
    .mem_rdy_i  (mem_rdy_i),
    .mem_data_i (mem_data_i),
    .pc_o       (pc_o),
    .mem_req_o  (mem_req_o),
    .mem_addr_o (mem_addr_o),
    .ir_o       (ir_o),
    .done_o     (done_o),
    .busy_o     (busy_o),
    .fault_o    (fault_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Architectural rule: absolute load beats offset commit; nothing changes otherwise.
  function automatic logic [15:0] upd_pc(input logic [15:0] pc, input logic wr, input logic [15:0] d,
                                         input logic upd, input logic [15:0] nx);
    if (wr)  return d;
    if (upd) return nx;
    return pc;
  endfunction

  task automatic clr_upd();
    pc_wr_i = 1'b0; pc_upd_i = 1'b0;
  endtask

  task automatic rnd_upd(input bit allow_odd);
    pc_wr_i   = ($urandom_range(0, 3) == 0);
    pc_upd_i  = ($urandom_range(0, 2) == 0);
    pc_data_i = 16'($urandom);
    pc_next_i = 16'($urandom) & 16'hFFFE;
    if (!allow_odd || $urandom_range(0, 5) != 0) pc_data_i[0] = 1'b0;
  endtask

  task automatic idle_cycle(input logic wr, input logic [15:0] d, input logic upd, input logic [15:0] nx);
    pc_wr_i = wr; pc_data_i = d; pc_upd_i = upd; pc_next_i = nx;
    m_pc = upd_pc(m_pc, wr, d, upd, nx);
    tick();
    clr_upd();
    chk("idle_pc", pc_o, m_pc);
  endtask

  // One fetch transaction: mem_rdy_i stays low for the first w REQ cycles.
  task automatic do_fetch(input int w, input logic [15:0] dat, input bit upd_same);
    logic [15:0] fpc;
    bit          flt;
    int          len;
    fpc = m_pc;
    chk("pre_busy", busy_o, 1'b0);
    fetch_i = 1'b1;
    if (upd_same) begin
      rnd_upd(1'b1);
      m_pc = upd_pc(m_pc, pc_wr_i, pc_data_i, pc_upd_i, pc_next_i);
    end
    tick();
    fetch_i = 1'b0;
    flt = fpc[0] || (w >= TMO);
    len = fpc[0] ? 1 : ((w >= TMO) ? TMO + 1 : w + 2);
    for (int k = 1; k <= len; k++) begin
      if (!flt && k == len) m_ir = dat;
      chk("busy",  busy_o,    1'b1);
      chk("req",   mem_req_o, (!fpc[0] && k < len));
      chk("done",  done_o,    (!flt && k == len));
      chk("fault", fault_o,   (flt && k == len));
      chk("pc",    pc_o,      m_pc);
      chk("ir",    ir_o,      m_ir);
      if (mem_req_o) chk("addr", mem_addr_o, fpc);
      mem_rdy_i  = (k > w);
      mem_data_i = (k == w + 1) ? dat : 16'($urandom);
      rnd_upd(1'b1);
      tick();
    end
    clr_upd();
    mem_rdy_i = 1'b0;
    chk("post_busy",  busy_o,  1'b0);
    chk("post_done",  done_o,  1'b0);
    chk("post_fault", fault_o, 1'b0);
    chk("post_ir",    ir_o,    m_ir);
    chk("post_pc",    pc_o,    m_pc);
  endtask

  initial begin
    arst_n_i = 1'b0;
    fetch_i = 1'b0; mem_rdy_i = 1'b0; mem_data_i = '0;
    pc_wr_i = 1'b0; pc_upd_i = 1'b0; pc_data_i = '0; pc_next_i = '0;
    m_pc = 16'h0000; m_ir = 16'h0000;
    #2;
    chk("rst_pc",    pc_o,       16'h0000);
    chk("rst_ir",    ir_o,       16'h0000);
    chk("rst_addr",  mem_addr_o, 16'h0000);
    chk("rst_strb",  {mem_req_o, done_o, busy_o, fault_o}, 4'b0000);
    #10 arst_n_i = 1'b1;
    tick();

    // Basic fetch with zero wait states.
    idle_cycle(1'b1, 16'h0100, 1'b0, 16'h0000);
    do_fetch(0, 16'hA5C3, 1'b0);
    chk("basic_ir", ir_o, 16'hA5C3);

    // Wait states, then commit the offset adder result.
    do_fetch(4, 16'h1234, 1'b0);
    idle_cycle(1'b0, 16'h0000, 1'b1, 16'h0102);
    chk("commit_pc", pc_o, 16'h0102);

    // Timeout and last-chance response.
    do_fetch(TMO + 3, 16'hDEAD, 1'b0);
    do_fetch(TMO - 1, 16'hBEEF, 1'b0);
    do_fetch(TMO, 16'hCAFE, 1'b0);

    // Absolute load wins, then a misaligned fetch faults without a request.
    idle_cycle(1'b1, 16'h0203, 1'b1, 16'h0300);
    chk("prio_pc", pc_o, 16'h0203);
    do_fetch(0, 16'h5555, 1'b0);

    // Wrap of the adder result is accepted as-is.
    idle_cycle(1'b1, 16'hFFFE, 1'b0, 16'h0000);
    do_fetch(1, 16'h7E7E, 1'b0);
    idle_cycle(1'b0, 16'h0000, 1'b1, 16'h0000);

    for (int i = 0; i < 40; i++) begin
      int nidle;
      int w;
      nidle = $urandom_range(0, 2);
      for (int j = 0; j < nidle; j++) begin
        rnd_upd(1'b1);
        idle_cycle(pc_wr_i, pc_data_i, pc_upd_i, pc_next_i);
      end
      w = ($urandom_range(0, 7) == 0) ? $urandom_range(TMO - 2, TMO + 2) : $urandom_range(0, 6);
      do_fetch(w, 16'($urandom), bit'($urandom_range(0, 1)));
    end

    // Reset in the middle of REQ drops the pending response.
    idle_cycle(1'b1, 16'h0440, 1'b0, 16'h0000);
    fetch_i = 1'b1;
    tick();
    fetch_i = 1'b0;
    tick();
    chk("mid_req", mem_req_o, 1'b1);
    #3 arst_n_i = 1'b0;
    #1;
    m_pc = 16'h0000; m_ir = 16'h0000;
    chk("arst_req",  mem_req_o, 1'b0);
    chk("arst_busy", busy_o,    1'b0);
    chk("arst_pc",   pc_o,      m_pc);
    chk("arst_ir",   ir_o,      m_ir);
    chk("arst_addr", mem_addr_o, 16'h0000);
    #2 arst_n_i = 1'b1;
    mem_rdy_i = 1'b1; mem_data_i = 16'h9999;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("arst_nodone", {done_o, busy_o, fault_o}, 3'b000);
      chk("arst_ir2",    ir_o, m_ir);
    end
    mem_rdy_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Owns the architectural program counter and fetches one instruction word per request from the control unit.
- Feeds its current PC to the PC offset adder and commits that adder's result (pc_next_i) as the next PC.
- Drives the instruction-memory request/ready handshake and latches the fetched word into the instruction register.
- Sits between the multi-cycle control unit, the PC offset adder and the instruction memory port.

Parameters:
- WORD, 16, datapath/address width in bits
- RESET_VEC, 16'h0000, PC value after reset
- TIMEOUT, 15, max cycles waiting for mem_rdy_i before a fault (1..255)

Ports:
- clk_i  input  1  clock, all state updates on rising edge
- arst_n_i  input  1  asynchronous active-low reset
- fetch_i  input  1  start a fetch at current PC (sampled in IDLE only)
- pc_upd_i  input  1  commit pc_next_i into PC
- pc_next_i  input  WORD  next PC from offset adder (pc + 2 or pc + branch)
- pc_wr_i  input  1  absolute PC load (jump/return)
- pc_data_i  input  WORD  absolute PC value
- mem_rdy_i  input  1  memory has valid data on mem_data_i
- mem_data_i  input  WORD  instruction word from memory
- pc_o  output  WORD  current PC, to offset adder and register file
- mem_req_o  output  1  memory read request
- mem_addr_o  output  WORD  fetch address
- ir_o  output  WORD  instruction register
- done_o  output  1  one-cycle pulse: ir_o updated
- busy_o  output  1  fetch in progress (state != IDLE)
- fault_o  output  1  one-cycle pulse: misaligned PC or timeout

Behaviour:
- Reset (async, arst_n_i low): pc_o = RESET_VEC; ir_o = 0; state = IDLE; mem_req_o, done_o, busy_o, fault_o = 0; mem_addr_o = 0; timeout counter = 0.
- States: IDLE, REQ, DONE, FAULT, held in a registered state variable.
- IDLE:
  - fetch_i = 1 with pc_o[0] = 0: go to REQ, mem_addr_o <= pc_o, counter cleared.
  - fetch_i = 1 with pc_o[0] = 1: go to FAULT; no memory request is issued.
- REQ:
  - mem_req_o = 1 and mem_addr_o is stable for the whole state.
  - mem_rdy_i = 1: ir_o <= mem_data_i, go to DONE. Minimum latency fetch_i to done_o is 2 cycles when mem_rdy_i is already high in the first REQ cycle.
  - Otherwise the counter increments. When the counter reaches TIMEOUT with mem_rdy_i still 0, go to FAULT; ir_o is unchanged.
  - mem_rdy_i outside REQ is ignored.
- DONE: done_o = 1 for exactly one cycle, then IDLE.
- FAULT: fault_o = 1 for exactly one cycle, then IDLE; pc_o is unchanged.
- Registered outputs: done_o, fault_o and mem_req_o are registered and decoded from state. busy_o = 1 in REQ, DONE and FAULT.
- PC update rules:
  - Accepted only in IDLE.
  - pc_wr_i has priority over pc_upd_i in the same cycle.
  - Outside IDLE, both are ignored and PC holds; the control unit sequences updates after done_o.
  - fetch_i and a PC update in the same IDLE cycle: the fetch uses the old PC, and the PC register takes the new value on that same edge.
- Arithmetic: no arithmetic in this block. The offset adder wraps modulo 2^WORD, so a wrap from 16'hFFFE + 2 = 16'h0000 is accepted as-is.
- fetch_i held high: after the return to IDLE, a new fetch starts on the next cycle.
- Reset mid-fetch: returns to IDLE immediately. The pending memory response is dropped; mem_req_o falls asynchronously.

Decomposition:
- Shared package (xm_pkg):
  - WORD
  - RESET_VEC
  - fetch_state_t enum {IDLE, REQ, DONE, FAULT}
- Sub-module fetch_timeout_cnt: clear, enable and expire on TIMEOUT, 8-bit counter. Everything else stays in one always_ff plus output decode.

Test Plan:
- Reset: assert arst_n_i mid-cycle -> pc_o = 16'h0000, ir_o = 0, all strobes 0 without a clock edge.
- Basic fetch: PC = 16'h0100, mem_rdy_i high immediately with data 16'hA5C3 -> mem_addr_o = 16'h0100 for 1 cycle, done_o pulse 2 cycles after fetch_i, ir_o = 16'hA5C3.
- Wait states then PC commit: mem_rdy_i after 5 cycles -> busy_o high 6 cycles, single done_o. Then pc_upd_i with pc_next_i = 16'h0102 -> pc_o = 16'h0102.
- Timeout: mem_rdy_i never asserted, TIMEOUT = 15 -> fault_o pulse after 15 REQ cycles, ir_o unchanged, state IDLE.
- Misalign and priority:
  - pc_wr_i = 1 with pc_data_i = 16'h0203, plus pc_upd_i = 1 with pc_next_i = 16'h0300, same cycle -> pc_o = 16'h0203.
  - fetch_i then -> fault_o, no mem_req_o.
- Updates during fetch: pc_upd_i and pc_wr_i pulsed while busy_o = 1 -> pc_o unchanged; reset during REQ -> mem_req_o drops, no done_o.
